shift_unit_seq: RTL and testbench
=================================

// Module: shift_unit_seq
// PURPOSE
//  Multi-cycle shift/rotate unit for the datapath ALU, successor to the single-cycle SHL path.
//  Supports SHL, SHR, SHRA, ROL and ROR on a WIDTH-bit operand. Shifts by at most STEP bits per clock.
//  Uses a start/busy/done handshake so the control unit can stall T-states until the result is ready for Z.
// PARAMETERS
//  WIDTH  32  operand/result width; power of two, >= 8
//  STEP   4   max bit positions shifted per clock; power of two, 1..WIDTH
//  SHW    $clog2(WIDTH)  localparam, shift-amount width
// PORTS
//  Clock      in   1      single clock, all state on rising edge
//  Clear      in   1      asynchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  op         in   3      000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, others illegal
//  A          in   WIDTH  operand (from Y/bus), captured on accepted start
//  shamt      in   SHW    shift amount, captured on accepted start
//  busy       out  1      high in SHIFT and DONE
//  done       out  1      one-cycle pulse, result valid
//  result     out  WIDTH  registered result, held until next accepted start
// BEHAVIOUR
//  - Clear (async, any state): state=IDLE, result=0, busy=0, done=0, internal acc/cnt/op=0.
//  - FSM states:
//    - IDLE: on start=1, latch acc=A, cnt=shamt, op_r=op, busy=1, then go to SHIFT. start=0 stays IDLE.
//    - SHIFT: if cnt==0, go to DONE and set result=acc.
//      Otherwise shift acc by k=min(cnt,STEP) per op_r, set cnt-=k, stay in SHIFT.
//    - DONE: done=1, busy=1 for exactly one cycle, then go to IDLE.
//  - Latency: n=ceil(shamt/STEP). done is high in the cycle after edge n+2 counted from the start edge.
//    shamt=0 gives done after 2 edges.
//  - Op semantics:
//    - SHL: zero-fill from LSB.
//    - SHR: zero-fill from MSB.
//    - SHRA: replicate A[WIDTH-1].
//    - ROL/ROR: bits wrap around, never lost.
//    - shamt is always < WIDTH, so no over-shift case exists.
//  - Illegal op: cnt forced to 0 at capture, so result=A unchanged and the same 2-edge latency applies.
//  - start while busy (SHIFT or DONE): ignored, not queued; A/shamt/op changes are ignored.
//  - start in the same cycle DONE exits: ignored. The requester must see done, then re-assert start in IDLE.
//  - result changes only on the SHIFT->DONE edge or on Clear.
//  - Clear mid-shift: operation aborted, no done pulse. Next start after Clear deasserts behaves normally.
// CONFIGURATION
//  - SHIFT_CARRY_OUT_EN defined: adds output port carry_out (1 bit).
//    - carry_out holds the last bit shifted out of the operand: MSB side for SHL/ROL, LSB side for SHR/SHRA/ROR.
//    - Updated at the same edge as result. Set to 0 on Clear, and when shamt=0 or op is illegal.
//  - SHIFT_CARRY_OUT_EN undefined: port and logic absent, all other behaviour identical.
// STRUCTURE
//  - Shared defines header (shift_defs.vh, also used by control unit):
//    - op encodings SHIFT_OP_SHL..SHIFT_OP_ROR
//    - FSM state encodings S_IDLE/S_SHIFT/S_DONE
//  - Sub-module shift_step: combinational, per-op shift of acc by k in 0..STEP.
//    Outputs the next acc and the last bit shifted out. Instantiated once.
//  - Top level holds the FSM, cnt down-counter, acc, result and optional carry registers.
// TESTING (WIDTH=32, STEP=4 unless noted)
//  1. SHL A=0x00000022 shamt=6 -> result=0x00000880; done pulse 4 edges after start edge; busy high throughout.
//  2. SHRA A=0x80000000 shamt=31 -> result=0xFFFFFFFF, n=8. SHR with the same inputs -> result=0x00000001.
//  3. ROR A=0x4A920000 shamt=16 -> 0x00004A92. ROL A=0x80000001 shamt=1 -> 0x00000003.
//  4. shamt=0 and op=3'b111 with A=0x12345678 -> result=0x12345678 after 2 edges. Re-pulse start during SHIFT -> ignored, exactly one done.
//  5. Assert Clear mid-SHIFT (SHL 0x1 by 28) -> busy=0, done=0, result=0 immediately.
//     Then SHL 0x1 by 28 -> result=0x10000000.
//  6. With SHIFT_CARRY_OUT_EN: SHL A=0x80000001 shamt=1 -> carry_out=1. SHR A=0x2 shamt=1 -> carry_out=0.
//     Repeat test 1 with STEP=1: done after 8 edges.

Source files
------------

// File: rtl/shift_unit_seq_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit:
// shift opcode encodings, FSM state encodings and the legal-op helper.
package shift_unit_seq_pkg;

  // Shift operation encodings as presented on the op port.
  typedef enum logic [2:0] {
    SHIFT_OP_SHL  = 3'b000,
    SHIFT_OP_SHR  = 3'b001,
    SHIFT_OP_SHRA = 3'b010,
    SHIFT_OP_ROL  = 3'b011,
    SHIFT_OP_ROR  = 3'b100
  } shift_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } shift_state_e;

  // Encodings above ROR are illegal; such requests pass A through unshifted.
  function automatic logic shift_op_legal(input logic [2:0] op);
    return (op <= 3'(SHIFT_OP_ROR));
  endfunction

endpackage

// File: rtl/shift_step.sv
// One shift step: moves acc by k (0..STEP) positions according to op and
// reports the last bit that left the operand. Purely combinational.
module shift_step
  import shift_unit_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [KW-1:0]    k,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] nxt,
  output logic             last_out
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW:0]       k_ext_s;
  logic [SHW:0]       inv_s;
  logic [SHW:0]       km1_s;
  logic [WIDTH-1:0]   lsh_s;
  logic [WIDTH-1:0]   rsh_s;
  logic [WIDTH-1:0]   ash_s;
  logic [WIDTH-1:0]   rol_s;
  logic [WIDTH-1:0]   ror_s;
  logic               hi_bit_s;
  logic               lo_bit_s;

  // Candidate results for every op plus the bits leaving each end.
  always_comb begin
    k_ext_s  = (SHW+1)'(k);
    inv_s    = (SHW+1)'(WIDTH) - k_ext_s;
    km1_s    = k_ext_s - (SHW+1)'(1);
    lsh_s    = acc << k_ext_s;
    rsh_s    = acc >> k_ext_s;
    ash_s    = $signed(acc) >>> k_ext_s;
    // With k=0 inv_s equals WIDTH, so the wrap terms shift to zero.
    rol_s    = lsh_s | (acc >> inv_s);
    ror_s    = rsh_s | (acc << inv_s);
    // Last bit leaving the MSB side is acc[WIDTH-k]; LSB side is acc[k-1].
    hi_bit_s = |(acc & (WIDTH'(1) << inv_s));
    lo_bit_s = |(acc & (WIDTH'(1) << km1_s));
  end

  // Select the result and carry for the requested op.
  always_comb begin
    nxt      = acc;
    last_out = 1'b0;
    case (op)
      SHIFT_OP_SHL: begin
        nxt      = lsh_s;
        last_out = hi_bit_s;
      end
      SHIFT_OP_SHR: begin
        nxt      = rsh_s;
        last_out = lo_bit_s;
      end
      SHIFT_OP_SHRA: begin
        nxt      = ash_s;
        last_out = lo_bit_s;
      end
      SHIFT_OP_ROL: begin
        nxt      = rol_s;
        last_out = hi_bit_s;
      end
      SHIFT_OP_ROR: begin
        nxt      = ror_s;
        last_out = lo_bit_s;
      end
      default: begin
        nxt      = acc;
        last_out = 1'b0;
      end
    endcase
    if (k == KW'(0)) begin
      last_out = 1'b0;
    end else begin
      last_out = last_out;
    end
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit (SHL, SHR, SHRA, ROL, ROR) with a
// start/busy/done handshake. At most STEP bit positions are shifted per clock.
// Optional feature macro: SHIFT_CARRY_OUT_EN adds the carry_out port, which
// holds the last bit shifted out of the operand.
module shift_unit_seq
  import shift_unit_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                     Clock,
  input  logic                     Clear,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         A,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result
`ifdef SHIFT_CARRY_OUT_EN
  ,
  output logic                     carry_out
`endif
);

  localparam int SHW = $clog2(WIDTH);
  localparam int KW  = $clog2(STEP) + 1;

  shift_state_e     state_r;
  logic [WIDTH-1:0] acc_r;
  logic [SHW-1:0]   cnt_r;
  logic [2:0]       op_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;

  logic [SHW:0]     cnt_ext_s;
  logic [KW-1:0]    k_s;
  logic [WIDTH-1:0] step_nxt_s;
  logic             step_last_s;

`ifdef SHIFT_CARRY_OUT_EN
  logic             carry_acc_r;
  logic             carry_out_r;
`else
  logic             unused_carry_s;
  assign unused_carry_s = step_last_s;
`endif

  // This cycle's step size: k = min(cnt, STEP).
  always_comb begin
    cnt_ext_s = {1'b0, cnt_r};
    if (cnt_ext_s > (SHW+1)'(STEP)) begin
      k_s = KW'(STEP);
    end else begin
      k_s = KW'(cnt_ext_s);
    end
  end

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .acc      (acc_r),
    .k        (k_s),
    .op       (op_r),
    .nxt      (step_nxt_s),
    .last_out (step_last_s)
  );

  // Sequencer: capture on start, shift in chunks, publish result, pulse done.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_r     <= S_IDLE;
      acc_r       <= '0;
      cnt_r       <= '0;
      op_r        <= 3'b000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= '0;
`ifdef SHIFT_CARRY_OUT_EN
      carry_acc_r <= 1'b0;
      carry_out_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            acc_r   <= A;
            // Illegal ops skip shifting entirely and return A unchanged.
            cnt_r   <= shift_op_legal(op) ? shamt : '0;
            op_r    <= op;
            busy_r  <= 1'b1;
            state_r <= S_SHIFT;
`ifdef SHIFT_CARRY_OUT_EN
            carry_acc_r <= 1'b0;
`endif
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (cnt_r == '0) begin
            result_r <= acc_r;
            done_r   <= 1'b1;
            state_r  <= S_DONE;
`ifdef SHIFT_CARRY_OUT_EN
            carry_out_r <= carry_acc_r;
`endif
          end else begin
            acc_r   <= step_nxt_s;
            cnt_r   <= cnt_r - SHW'(k_s);
            state_r <= S_SHIFT;
`ifdef SHIFT_CARRY_OUT_EN
            carry_acc_r <= step_last_s;
`endif
          end
        end
        S_DONE: begin
          // A start seen on this exit edge is deliberately dropped.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
`ifdef SHIFT_CARRY_OUT_EN
  assign carry_out = carry_out_r;
`endif

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq (WIDTH=32, STEP=4, plus a STEP=1 instance).
module tb_shift_unit_seq;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        start;
  logic        start1;
  logic [2:0]  op;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic        busy, done, busy1, done1;
  logic [31:0] result, result1;
`ifdef SHIFT_CARRY_OUT_EN
  logic        carry_out, carry1;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res = 32'h0;
  logic        m_carry = 1'b0;
  logic [32:0] m_pend = 33'h0;

  always #5 Clock = ~Clock;

  shift_unit_seq #(.WIDTH(32), .STEP(4)) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .op(op), .A(A), .shamt(shamt),
    .busy(busy), .done(done), .result(result)
`ifdef SHIFT_CARRY_OUT_EN
    , .carry_out(carry_out)
`endif
  );

  shift_unit_seq #(.WIDTH(32), .STEP(1)) dut1 (
    .Clock(Clock), .Clear(Clear), .start(start1), .op(op), .A(A), .shamt(shamt),
    .busy(busy1), .done(done1), .result(result1)
`ifdef SHIFT_CARRY_OUT_EN
    , .carry_out(carry1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One bit position at a time; returns {carry, value}.
  function automatic logic [32:0] model_shift(input logic [2:0] o, input logic [31:0] a, input int sh);
    logic        c = 1'b0;
    logic [31:0] v = a;
    if (o > 3'd4) return {1'b0, a};
    for (int i = 0; i < sh; i++) begin
      case (o)
        3'd0:    begin c = v[31]; v = {v[30:0], 1'b0};  end
        3'd1:    begin c = v[0];  v = {1'b0, v[31:1]};  end
        3'd2:    begin c = v[0];  v = {v[31], v[31:1]}; end
        3'd3:    begin c = v[31]; v = {v[30:0], v[31]}; end
        default: begin c = v[0];  v = {v[0], v[31:1]};  end
      endcase
    end
    return {c, v};
  endfunction

  // Edges from start edge (counted as 1) to the edge that raises done.
  function automatic int model_edges(input logic [2:0] o, input int sh, input int step);
    if (o > 3'd4 || sh == 0) return 2;
    return (sh + step - 1) / step + 2;
  endfunction

  // Model of the handshake and result timing.
  always @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_res <= 32'h0; m_carry <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_pend <= model_shift(op, A, int'(shamt));
        m_left <= model_edges(op, int'(shamt), 4) - 1;
      end
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0;
    end else begin
      if (m_left == 1) begin
        m_done <= 1'b1; m_res <= m_pend[31:0]; m_carry <= m_pend[32];
      end
      m_left <= m_left - 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("cyc_busy", {31'h0, busy}, {31'h0, m_busy});
      chk("cyc_done", {31'h0, done}, {31'h0, m_done});
      chk("cyc_result", result, m_res);
`ifdef SHIFT_CARRY_OUT_EN
      chk("cyc_carry", {31'h0, carry_out}, {31'h0, m_carry});
`endif
    end
  end

  // Done-pulse counter.
  always @(negedge Clock) if (done) done_cnt <= done_cnt + 1;

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [4:0] sh,
                        input logic [31:0] exp_res, input int exp_edges, input string name,
                        input bit repulse, input bit hold);
    int edges = 0;
    bit got = 1'b0;
    int d0;
    @(negedge Clock);
    op = o; A = a; shamt = sh; start = 1'b1; d0 = done_cnt;
    while (!got && edges < 100) begin
      @(posedge Clock); edges++; #1;
      if (!hold) start = 1'b0;
      if (repulse && edges == 2) begin start = 1'b1; A = ~a; op = 3'd1; shamt = 5'd3; end
      if (done) got = 1'b1;
    end
    chk({name, "_done_seen"}, {31'h0, got}, 32'h1);
    chk({name, "_edges"}, 32'(edges), 32'(exp_edges));
    chk({name, "_result"}, result, exp_res);
    if (hold) begin
      @(posedge Clock); #1; start = 1'b0;
      chk({name, "_start_at_exit_ignored"}, {31'h0, busy}, 32'h0);
    end
    start = 1'b0;
    repeat (3) @(negedge Clock);
    chk({name, "_one_done"}, 32'(done_cnt - d0), 32'h1);
  endtask

  initial begin
    logic [32:0] mv;
    int edges1;
    bit got1;
    Clear = 1'b1; start = 1'b0; start1 = 1'b0; op = 3'd0; A = 32'h0; shamt = 5'd0;
    repeat (2) @(negedge Clock);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    Clear = 1'b0;
    cmp_en = 1'b1;

    // Pin the model with hand-computed values.
    mv = model_shift(3'd0, 32'h00000022, 6);  chk("model_shl", mv[31:0], 32'h00000880);
    mv = model_shift(3'd2, 32'h80000000, 31); chk("model_shra", mv[31:0], 32'hFFFFFFFF);
    mv = model_shift(3'd4, 32'h4A920000, 16); chk("model_ror", mv[31:0], 32'h00004A92);
    mv = model_shift(3'd1, 32'h80000000, 31); chk("model_shr", mv[31:0], 32'h00000001);

    run_op(3'd0, 32'h00000022, 5'd6,  32'h00000880, 4,  "shl6",   1'b0, 1'b0);
    run_op(3'd2, 32'h80000000, 5'd31, 32'hFFFFFFFF, 10, "shra31", 1'b0, 1'b0);
    run_op(3'd1, 32'h80000000, 5'd31, 32'h00000001, 10, "shr31",  1'b0, 1'b0);
    run_op(3'd4, 32'h4A920000, 5'd16, 32'h00004A92, 6,  "ror16",  1'b0, 1'b0);
    run_op(3'd3, 32'h80000001, 5'd1,  32'h00000003, 3,  "rol1",   1'b0, 1'b0);
    run_op(3'd3, 32'hF000000F, 5'd7,  32'h000007F8, 4,  "rol7",   1'b0, 1'b0);
    run_op(3'd2, 32'h40000000, 5'd5,  32'h02000000, 4,  "shra_pos", 1'b0, 1'b0);
    run_op(3'd0, 32'h12345678, 5'd0,  32'h12345678, 2,  "shamt0", 1'b0, 1'b0);
    run_op(3'd7, 32'h12345678, 5'd5,  32'h12345678, 2,  "illegal", 1'b0, 1'b0);
    run_op(3'd0, 32'h00000022, 5'd20, 32'h02200000, 7,  "repulse", 1'b1, 1'b0);
    run_op(3'd4, 32'h00000001, 5'd4,  32'h10000000, 3,  "hold",   1'b0, 1'b1);

    run_op(3'd0, 32'h80000001, 5'd1,  32'h00000002, 3,  "shl_c",  1'b0, 1'b0);
`ifdef SHIFT_CARRY_OUT_EN
    chk("carry_shl", {31'h0, carry_out}, 32'h1);
`endif
    run_op(3'd1, 32'h00000002, 5'd1,  32'h00000001, 3,  "shr_c",  1'b0, 1'b0);
`ifdef SHIFT_CARRY_OUT_EN
    chk("carry_shr", {31'h0, carry_out}, 32'h0);
`endif

    // Clear during SHIFT aborts the operation.
    @(negedge Clock);
    op = 3'd0; A = 32'h1; shamt = 5'd28; start = 1'b1;
    @(posedge Clock); #1; start = 1'b0;
    repeat (2) @(posedge Clock);
    #1; Clear = 1'b1; #1;
    chk("clear_busy", {31'h0, busy}, 32'h0);
    chk("clear_done", {31'h0, done}, 32'h0);
    chk("clear_result", result, 32'h0);
    @(negedge Clock); Clear = 1'b0;
    run_op(3'd0, 32'h00000001, 5'd28, 32'h10000000, 9, "after_clear", 1'b0, 1'b0);

    // STEP=1 instance: latency grows to shamt+2 edges.
    @(negedge Clock);
    op = 3'd0; A = 32'h00000022; shamt = 5'd6; start1 = 1'b1;
    edges1 = 0; got1 = 1'b0;
    while (!got1 && edges1 < 100) begin
      @(posedge Clock); edges1++; #1;
      start1 = 1'b0;
      if (done1) got1 = 1'b1;
    end
    chk("step1_done_seen", {31'h0, got1}, 32'h1);
    chk("step1_edges", 32'(edges1), 32'd8);
    chk("step1_result", result1, 32'h00000880);

    repeat (2) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
